// File: rtl/ycr_cclk_pkg.sv
// Shared types for the core-clock sleep/wake sequencer: the per-core state codes
// and the width of the per-core hold-off counter.
package ycr_cclk_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_HOLD  = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WPEND = 3'd4,
        ST_WAKE  = 3'd5
    } cclk_seq_st_t;

    localparam int CCLK_CNT_W = 8;

    // The gate is held closed while asleep and while waiting for a wake grant.
    function automatic logic seq_gated(cclk_seq_st_t st);
        return (st == ST_SLEEP) || (st == ST_WPEND);
    endfunction

endpackage

// File: rtl/ycr_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer;
// the pointer moves just past the winner and holds when nothing is granted.
module ycr_rr_arb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr_reg;
    logic [PW-1:0]  ptr_next;
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   first_rot;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    assign req_dbl   = {req, req};
    assign req_rot   = req_dbl[ptr_reg +: N];
    assign first_rot = req_rot & (~req_rot + 1'b1);
    assign gnt_dbl   = {{N{1'b0}}, first_rot} << ptr_reg;
    assign gnt       = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

    always_comb begin
        ptr_next = ptr_reg;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/ycr_cclk_sleep_seq.sv
// Per-core sleep/wake sequencer feeding the core clock gates; wake-ups are
// serialised through a round-robin arbiter so only one clock restarts per cycle.
module ycr_cclk_sleep_seq
    import ycr_cclk_pkg::*;
#(
    parameter int NCORE = 8
) (
    input  logic                 core_clk,
    input  logic                 srst,
    input  logic [NCORE-1:0]     cfg_enb,
    input  logic [7:0]           cfg_idle_dly,
    input  logic [3:0]           cfg_wake_dly,
    input  logic [NCORE-1:0]     wfi_req,
    input  logic [NCORE-1:0]     bus_busy,
    input  logic [NCORE-1:0]     irq_pend,
    input  logic [NCORE-1:0]     riscv_wakeup,
    output logic [NCORE-1:0]     riscv_sleep,
    output logic [NCORE-1:0]     wake_done,
    output logic [3*NCORE-1:0]   core_state
);
    logic [NCORE-1:0] wake_req;
    logic [NCORE-1:0] wake_gnt;

    ycr_rr_arb #(.N(NCORE)) u_wake_arb (
        .clk  (core_clk),
        .srst (srst),
        .req  (wake_req),
        .gnt  (wake_gnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCORE; gi++) begin : g_core
            cclk_seq_st_t          state_reg;
            logic [CCLK_CNT_W-1:0] cnt_reg;
            logic                  wake_done_reg;
            logic                  abort;

            // Any reason the core should not (or can no longer) go to sleep.
            assign abort = irq_pend[gi] | ~wfi_req[gi] | ~cfg_enb[gi];

            always_ff @(posedge core_clk) begin
                if (srst) begin
                    state_reg     <= ST_RUN;
                    cnt_reg       <= '0;
                    wake_done_reg <= 1'b0;
                end else begin
                    wake_done_reg <= 1'b0;
                    case (state_reg)
                        ST_RUN: begin
                            if (!abort) state_reg <= ST_DRAIN;
                        end
                        ST_DRAIN: begin
                            if (abort) begin
                                state_reg <= ST_RUN;
                            end else if (!bus_busy[gi]) begin
                                state_reg <= ST_HOLD;
                                cnt_reg   <= cfg_idle_dly;
                            end
                        end
                        ST_HOLD: begin
                            if (abort || bus_busy[gi]) begin
                                state_reg <= ST_RUN;
                            end else if (cnt_reg == '0) begin
                                state_reg <= ST_SLEEP;
                            end else begin
                                cnt_reg <= cnt_reg - 1'b1;
                            end
                        end
                        ST_SLEEP: begin
                            if (riscv_wakeup[gi] || irq_pend[gi] || !cfg_enb[gi]) state_reg <= ST_WPEND;
                        end
                        ST_WPEND: begin
                            if (wake_gnt[gi]) begin
                                state_reg <= ST_WAKE;
                                cnt_reg   <= {{(CCLK_CNT_W-4){1'b0}}, cfg_wake_dly};
                            end
                        end
                        ST_WAKE: begin
                            if (cnt_reg == '0) begin
                                state_reg     <= ST_RUN;
                                wake_done_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg - 1'b1;
                            end
                        end
                        default: state_reg <= ST_RUN;
                    endcase
                end
            end

            assign wake_req[gi]            = (state_reg == ST_WPEND);
            assign riscv_sleep[gi]         = seq_gated(state_reg);
            assign wake_done[gi]           = wake_done_reg;
            assign core_state[3*gi +: 3]   = state_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ycr_cclk_sleep_seq.sv
// Bench for ycr_cclk_sleep_seq: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a cycle reference model.
module tb_ycr_cclk_sleep_seq;

    logic        core_clk;
    logic        srst;
    logic [7:0]  cfg_enb;
    logic [7:0]  cfg_idle_dly;
    logic [3:0]  cfg_wake_dly;
    logic [7:0]  wfi_req;
    logic [7:0]  bus_busy;
    logic [7:0]  irq_pend;
    logic [7:0]  riscv_wakeup;
    logic [7:0]  riscv_sleep;
    logic [7:0]  wake_done;
    logic [23:0] core_state;

    ycr_cclk_sleep_seq #(.NCORE(8)) dut (
        .core_clk     (core_clk),
        .srst         (srst),
        .cfg_enb      (cfg_enb),
        .cfg_idle_dly (cfg_idle_dly),
        .cfg_wake_dly (cfg_wake_dly),
        .wfi_req      (wfi_req),
        .bus_busy     (bus_busy),
        .irq_pend     (irq_pend),
        .riscv_wakeup (riscv_wakeup),
        .riscv_sleep  (riscv_sleep),
        .wake_done    (wake_done),
        .core_state   (core_state)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase per core plus a countdown; the arbiter is a plain
    // modular scan for the first waiting core starting at the pointer.
    localparam int RUN = 0, DRAIN = 1, HOLD = 2, SLEEP = 3, WPEND = 4, WAKE = 5;
    int m_st[8];
    int m_cnt[8];
    bit m_done[8];
    int m_ptr = 0;

    function automatic void model_step();
        int g;
        if (srst) begin
            for (int i = 0; i < 8; i++) begin
                m_st[i] = RUN; m_cnt[i] = 0; m_done[i] = 0;
            end
            m_ptr = 0;
            return;
        end
        g = -1;
        for (int k = 0; k < 8; k++) begin
            int c = (m_ptr + k) % 8;
            if (g < 0 && m_st[c] == WPEND) g = c;
        end
        if (g >= 0) m_ptr = (g + 1) % 8;
        for (int i = 0; i < 8; i++) begin
            bit quit = irq_pend[i] || !wfi_req[i] || !cfg_enb[i];
            m_done[i] = 0;
            case (m_st[i])
                RUN:   if (!quit) m_st[i] = DRAIN;
                DRAIN: if (quit) m_st[i] = RUN;
                       else if (!bus_busy[i]) begin m_st[i] = HOLD; m_cnt[i] = int'(cfg_idle_dly); end
                HOLD:  if (quit || bus_busy[i]) m_st[i] = RUN;
                       else if (m_cnt[i] == 0) m_st[i] = SLEEP;
                       else m_cnt[i]--;
                SLEEP: if (riscv_wakeup[i] || irq_pend[i] || !cfg_enb[i]) m_st[i] = WPEND;
                WPEND: if (g == i) begin m_st[i] = WAKE; m_cnt[i] = int'(cfg_wake_dly); end
                WAKE:  if (m_cnt[i] == 0) begin m_st[i] = RUN; m_done[i] = 1; end
                       else m_cnt[i]--;
                default: m_st[i] = RUN;
            endcase
        end
    endfunction

    // One clock: advance the model on the current inputs, then compare just after the edge.
    task automatic step();
        logic [7:0]  es, ed;
        logic [23:0] est;
        model_step();
        @(posedge core_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            es[i] = (m_st[i] == SLEEP || m_st[i] == WPEND);
            ed[i] = m_done[i];
            est[3*i +: 3] = 3'(m_st[i]);
        end
        check("model_sleep", {24'd0, riscv_sleep}, {24'd0, es});
        check("model_done",  {24'd0, wake_done},   {24'd0, ed});
        check("model_state", {8'd0, core_state},   {8'd0, est});
    endtask

    task automatic clear_inputs();
        cfg_enb = '0; cfg_idle_dly = '0; cfg_wake_dly = '0;
        wfi_req = '0; bus_busy = '0; irq_pend = '0; riscv_wakeup = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        srst = 1'b1;
        step();
        srst = 1'b0;
    endtask

    typedef struct {
        logic       wfi;
        logic       bus;
        logic       irq;
        logic       wak;
        logic [2:0] st;
        logic       slp;
        logic       done;
    } vec_t;

    vec_t tbl[12];
    int   pulses;

    initial begin
        // Core 0, D=3, K=1: sleep entry then wake-up, one edge per row.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

        srst = 1'b1;
        clear_inputs();
        step();
        step();
        check("reset_state", {8'd0, core_state}, 32'd0);
        check("reset_sleep", {24'd0, riscv_sleep}, 32'd0);
        check("reset_done",  {24'd0, wake_done}, 32'd0);
        srst = 1'b0;

        cfg_enb = 8'h01; cfg_idle_dly = 8'd3; cfg_wake_dly = 4'd1;
        for (int v = 0; v < 12; v++) begin
            wfi_req[0] = tbl[v].wfi; bus_busy[0] = tbl[v].bus;
            irq_pend[0] = tbl[v].irq; riscv_wakeup[0] = tbl[v].wak;
            step();
            check("vec_state", {29'd0, core_state[2:0]}, {29'd0, tbl[v].st});
            check("vec_sleep", {31'd0, riscv_sleep[0]},  {31'd0, tbl[v].slp});
            check("vec_done",  {31'd0, wake_done[0]},    {31'd0, tbl[v].done});
            $display("vec %0d: state=%0d sleep=%0b done=%0b", v, core_state[2:0], riscv_sleep[0], wake_done[0]);
        end

        // Interrupt aborts HOLD with two counts left.
        do_reset();
        cfg_enb = 8'h01; cfg_idle_dly = 8'd5; wfi_req = 8'h01;
        repeat (5) step();
        check("hold_reached", {29'd0, core_state[2:0]}, 32'd2);
        irq_pend = 8'h01;
        step();
        check("abort_state", {29'd0, core_state[2:0]}, 32'd0);
        check("abort_sleep", {31'd0, riscv_sleep[0]}, 32'd0);
        irq_pend = 8'h00; wfi_req = 8'h00;
        step();
        check("abort_nodone", {31'd0, wake_done[0]}, 32'd0);
        $display("seq hold-abort: state=%0d", core_state[2:0]);

        // Bus busy keeps core 1 in DRAIN.
        do_reset();
        cfg_enb = 8'h02; wfi_req = 8'h02; bus_busy = 8'h02;
        step();
        for (int n = 0; n < 10; n++) begin
            step();
            check("drain_busy", {29'd0, core_state[5:3]}, 32'd1);
        end
        bus_busy = 8'h00;
        step();
        check("drain_to_hold", {29'd0, core_state[5:3]}, 32'd2);
        $display("seq drain-busy: state=%0d", core_state[5:3]);

        // Disabling a sleeping core wakes it.
        do_reset();
        cfg_enb = 8'h04; wfi_req = 8'h04; cfg_wake_dly = 4'd2;
        repeat (3) step();
        check("c2_asleep", {29'd0, core_state[8:6]}, 32'd3);
        wfi_req = 8'h00; cfg_enb = 8'h00;
        step();
        check("c2_wpend", {29'd0, core_state[8:6]}, 32'd4);
        step();
        check("c2_wake", {29'd0, core_state[8:6]}, 32'd5);
        pulses = 0;
        repeat (6) begin
            step();
            pulses += int'(wake_done[2]);
        end
        check("c2_done_once", 32'(pulses), 32'd1);
        check("c2_run", {29'd0, core_state[8:6]}, 32'd0);
        $display("seq disable-wake: pulses=%0d", pulses);

        // Everything asleep, then a one-edge reset releases all gates at once.
        do_reset();
        cfg_enb = 8'hFF; wfi_req = 8'hFF;
        repeat (3) step();
        check("all_asleep", {24'd0, riscv_sleep}, 32'hFF);
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("rst_sleep", {24'd0, riscv_sleep}, 32'd0);
        check("rst_state", {8'd0, core_state}, 32'd0);
        check("rst_done",  {24'd0, wake_done}, 32'd0);
        $display("seq mid-reset: sleep=%0h", riscv_sleep);

        // Simultaneous wake of 0,3,5 with the pointer freshly reset.
        cfg_enb = 8'h29; wfi_req = 8'h29; cfg_idle_dly = 8'd0; cfg_wake_dly = 4'd0;
        repeat (3) step();
        check("rr_asleep", {24'd0, riscv_sleep}, 32'h29);
        wfi_req = 8'h00; riscv_wakeup = 8'h29;
        step();
        riscv_wakeup = 8'h00;
        step();
        check("rr_first_wake", {24'd0, wake_done}, 32'h00);
        step();
        check("rr_done0", {24'd0, wake_done}, 32'h01);
        step();
        check("rr_done3", {24'd0, wake_done}, 32'h08);
        step();
        check("rr_done5", {24'd0, wake_done}, 32'h20);
        $display("seq rr-wake: sleep=%0h", riscv_sleep);

        // Randomized traffic against the model.
        do_reset();
        cfg_enb = 8'hFF; wfi_req = 8'hFF; cfg_idle_dly = 8'd2; cfg_wake_dly = 4'd1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(15) == 0) wfi_req[i] = ~wfi_req[i];
                bus_busy[i]     = ($urandom_range(7) == 0);
                irq_pend[i]     = ($urandom_range(63) == 0);
                riscv_wakeup[i] = ($urandom_range(15) == 0);
                if ($urandom_range(127) == 0) cfg_enb[i] = ~cfg_enb[i];
            end
            if ($urandom_range(31) == 0) cfg_idle_dly = 8'($urandom_range(6));
            if ($urandom_range(31) == 0) cfg_wake_dly = 4'($urandom_range(3));
            srst = ($urandom_range(499) == 0);
            step();
        end
        srst = 1'b0;
        $display("random phase complete: %0d cycles", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
